// File: rtl/ssd_scan_ctrl_if.sv
// Interface for the multiplexed seven-segment scan controller: the display data
// and load strobe going in, and the SSD pin drives and status coming out.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_suppress;
    logic                    load;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   An;
    logic [6:0]              Cathodes;
    logic                    Dp;
    logic                    frame_done;

    modport master (
        output digits, dp_in, blank_mask, blink_mask, lz_suppress, load,
        input  pending, An, Cathodes, Dp, frame_done
    );

    modport slave (
        input  digits, dp_in, blank_mask, blink_mask, lz_suppress, load,
        output pending, An, Cathodes, Dp, frame_done
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed SSD scanner with guard interval, blink, leading-zero
// suppression and staging/shadow registers committed at frame wrap.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV_BITS  = 18,
    parameter int GUARD_CYCLES   = 4,
    parameter int BLINK_DIV_BITS = 25
) (
    input  logic              board_clk,
    input  logic              reset_n,
    ssd_scan_ctrl_if.slave    bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_BITS-1:0] GUARD    = SCAN_DIV_BITS'(GUARD_CYCLES);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
        logic                    lz;
    } frame_t;

    logic [SCAN_DIV_BITS-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BLINK_DIV_BITS-1:0] blink_q, blink_d;
    frame_t                    stg_q, stg_d;
    frame_t                    shd_q, shd_d;
    logic                      pending_q, pending_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [6:0]                cath_q, cath_d;
    logic                      dp_q, dp_d;
    logic                      frame_done_q, frame_done_d;

    logic                      tick;
    logic                      wrap;
    logic                      lead;
    logic [NUM_DIGITS-1:0]     sup;
    logic [3:0]                nib;
    logic                      dark;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0001100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Timing, staging and commit
    always_comb begin
        tick         = &presc_q;
        wrap         = tick && (idx_q == LAST_IDX);
        presc_d      = presc_q + 1'b1;
        blink_d      = blink_q + 1'b1;
        idx_d        = idx_q;
        stg_d        = stg_q;
        shd_d        = shd_q;
        pending_d    = pending_q;
        frame_done_d = wrap;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        // Commit reads the old staging, so a coincident load lands one frame later.
        if (wrap) begin
            shd_d     = stg_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            stg_d.digits = bus.digits;
            stg_d.dp     = bus.dp_in;
            stg_d.blank  = bus.blank_mask;
            stg_d.blink  = bus.blink_mask;
            stg_d.lz     = bus.lz_suppress;
            pending_d    = 1'b1;
        end
    end

    // Leading zeros are found top-down; digit 0 always stays visible.
    always_comb begin
        lead = shd_q.lz;
        sup  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (shd_q.digits[4*i +: 4] != 4'h0) begin
                lead = 1'b0;
            end
            sup[i] = lead;
        end
    end

    always_comb begin
        nib    = shd_q.digits[4*int'(idx_q) +: 4];
        dark   = shd_q.blank[idx_q]
               | (shd_q.blink[idx_q] & blink_q[BLINK_DIV_BITS-1])
               | sup[idx_q]
               | (presc_q < GUARD);
        an_d   = '1;
        cath_d = 7'b1111111;
        dp_d   = 1'b1;
        if (!dark) begin
            an_d[idx_q] = 1'b0;
            cath_d      = seg7(nib);
            dp_d        = ~shd_q.dp[idx_q];
        end
    end

    always_ff @(posedge board_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            blink_q      <= '0;
            stg_q        <= '0;
            shd_q        <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            cath_q       <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            blink_q      <= blink_d;
            stg_q        <= stg_d;
            shd_q        <= shd_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.An         = an_q;
    assign bus.Cathodes   = cath_q;
    assign bus.Dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a time-based reference model predicts every
// cycle's pin state; a negedge monitor pops and compares.
module tb_ssd_scan_ctrl;
    localparam int N     = 3;
    localparam int SD    = 3;
    localparam int G     = 2;
    localparam int BB    = 7;
    localparam int SLOT  = 1 << SD;
    localparam int FRAME = SLOT * N;
    localparam int BPER  = 1 << BB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ssd_scan_ctrl_if #(.NUM_DIGITS(N)) bus();

    ssd_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV_BITS(SD), .GUARD_CYCLES(G), .BLINK_DIV_BITS(BB)
    ) dut (
        .board_clk(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int dig[N];
        bit dp[N];
        bit blank[N];
        bit blink[N];
        bit lz;
    } cfg_t;

    typedef struct {
        logic [N-1:0] an;
        logic [6:0]   cath;
        logic         dp;
        logic         fd;
        logic         pend;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] seg_tab [16];

    initial seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cfg_t zero_cfg();
        cfg_t c;
        for (int k = 0; k < N; k++) begin
            c.dig[k] = 0; c.dp[k] = 0; c.blank[k] = 0; c.blink[k] = 0;
        end
        c.lz = 0;
        return c;
    endfunction

    function automatic cfg_t sample_cfg();
        cfg_t c;
        for (int k = 0; k < N; k++) begin
            c.dig[k]   = int'(bus.digits[4*k +: 4]);
            c.dp[k]    = bus.dp_in[k];
            c.blank[k] = bus.blank_mask[k];
            c.blink[k] = bus.blink_mask[k];
        end
        c.lz = bus.lz_suppress;
        return c;
    endfunction

    // Pin state produced from elapsed time since reset and the frame contents shown.
    function automatic exp_t predict(input int tt, input cfg_t s);
        exp_t e;
        int   slot, pos, phase;
        bit   supp, dark;
        slot  = (tt / SLOT) % N;
        pos   = tt % SLOT;
        phase = (tt / (BPER / 2)) % 2;
        supp  = 0;
        if (s.lz && slot > 0) begin
            supp = 1;
            for (int k = slot; k < N; k++) if (s.dig[k] != 0) supp = 0;
        end
        dark   = (pos < G) || s.blank[slot] || (s.blink[slot] && phase == 1) || supp;
        e.an   = '1;
        e.cath = 7'b1111111;
        e.dp   = 1'b1;
        e.fd   = 1'b0;
        e.pend = 1'b0;
        if (!dark) begin
            e.an   = ~(N'(1) << slot);
            e.cath = seg_tab[s.dig[slot]];
            e.dp   = ~s.dp[slot];
        end
        return e;
    endfunction

    int   m_t;
    cfg_t m_stg, m_shd;
    bit   m_pend;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   commit;
        if (!rst_n) begin
            m_t    = 0;
            m_stg  = zero_cfg();
            m_shd  = zero_cfg();
            m_pend = 0;
            sbq.delete();
        end else begin
            e      = predict(m_t, m_shd);
            commit = (m_t % FRAME) == FRAME - 1;
            e.fd   = commit;
            if (commit) m_shd = m_stg;
            if (bus.load) m_stg = sample_cfg();
            m_pend = bus.load ? 1'b1 : (commit ? 1'b0 : m_pend);
            e.pend = m_pend;
            sbq.push_back(e);
            m_t++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            check("An", 32'(bus.An), 32'(e.an));
            check("Cathodes", 32'(bus.Cathodes), 32'(e.cath));
            check("Dp", 32'(bus.Dp), 32'(e.dp));
            check("frame_done", 32'(bus.frame_done), 32'(e.fd));
            check("pending", 32'(bus.pending), 32'(e.pend));
        end
    end

    task automatic do_load(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] bl,
                           input logic [2:0] bk, input logic lz);
        bus.digits      = d;
        bus.dp_in       = dp;
        bus.blank_mask  = bl;
        bus.blink_mask  = bk;
        bus.lz_suppress = lz;
        bus.load        = 1'b1;
        @(negedge clk);
        bus.load        = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
        end
        if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_An"}, 32'(bus.An), 32'(3'b111));
        check({tag, "_Cathodes"}, 32'(bus.Cathodes), 32'(7'b1111111));
        check({tag, "_Dp"}, 32'(bus.Dp), 32'd1);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_pending"}, 32'(bus.pending), 32'd0);
    endtask

    initial begin
        int first;
        bus.digits = '0; bus.dp_in = '0; bus.blank_mask = '0; bus.blink_mask = '0;
        bus.lz_suppress = 1'b0; bus.load = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_dark("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic scan with guard interval
        do_load(12'h5A0, 3'b000, 3'b000, 3'b000, 1'b0);
        repeat (3 * FRAME) @(negedge clk);

        // Last load before commit wins
        repeat (5) @(negedge clk);
        do_load(12'h123, 3'b000, 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        do_load(12'h456, 3'b000, 3'b000, 3'b000, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Load coincident with the wrap tick
        wait_fd();
        repeat (4) @(negedge clk);
        do_load(12'h321, 3'b000, 3'b000, 3'b000, 1'b0);
        repeat (FRAME - 6) @(negedge clk);
        do_load(12'h777, 3'b000, 3'b000, 3'b000, 1'b0);
        repeat (3 * FRAME) @(negedge clk);

        // Leading-zero suppression
        do_load(12'h005, 3'b000, 3'b000, 3'b000, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(12'h000, 3'b000, 3'b000, 3'b000, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(12'h050, 3'b000, 3'b000, 3'b000, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        // Blink and decimal point
        do_load(12'(($urandom % 16'hFFF) | 12'h111), 3'b001, 3'b000, 3'b010, 1'b0);
        repeat (3 * BPER) @(negedge clk);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            do_load(12'($urandom), 3'($urandom), 3'($urandom_range(0, 7) & 3'($urandom)),
                    3'($urandom), 1'($urandom));
        end
        repeat (2 * FRAME) @(negedge clk);

        // Asynchronous reset mid-slot
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_dark("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 10 && first < 0; i++) begin
            @(negedge clk);
            if (bus.An != 3'b111) begin
                first = i;
                check("first_lit_An", 32'(bus.An), 32'(3'b110));
                check("first_lit_Cathodes", 32'(bus.Cathodes), 32'(7'b0000001));
            end
        end
        check("first_lit_cycles", 32'(first), 32'(G + 1));
        repeat (2 * FRAME) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment scan controller, reused by every lab top that drives the board SSDs.
- Takes packed hex nibbles plus per-digit decimal-point, blank and blink masks, and drives active-low anodes, cathodes and Dp.
- Adds a non-power-of-2 digit count, an anti-ghosting guard interval, blinking, leading-zero suppression and frame-synchronous atomic update.
- Sits between board_clk and the SSD pins; replaces hand-written scan/decoder logic in each top.

Parameters:
- NUM_DIGITS, 4, digits scanned (1..16, need not be a power of 2).
- SCAN_DIV_BITS, 18, digit slot length = 2^SCAN_DIV_BITS clocks.
- GUARD_CYCLES, 4, all-anodes-off clocks at the start of each slot; must be < 2^SCAN_DIV_BITS.
- BLINK_DIV_BITS, 25, blink phase = MSB of a BLINK_DIV_BITS-bit free-running counter.

Ports:
- board_clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
- dp_in  in  NUM_DIGITS  1 = decimal point lit.
- blank_mask  in  NUM_DIGITS  1 = digit dark.
- blink_mask  in  NUM_DIGITS  1 = digit dark while blink phase = 1.
- lz_suppress  in  1  1 = blank leading zero digits.
- load  in  1  one-cycle strobe; captures all inputs above into staging.
- pending  out  1  staging holds data not yet committed.
- An  out  NUM_DIGITS  active-low anodes.
- Cathodes  out  7  active-low segments; bit6 = Ca … bit0 = Cg.
- Dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset (async, while reset_n = 0): prescaler, idx, blink counter, staging and shadow registers = 0; pending = 0; An = all 1; Cathodes = 7'b1111111; Dp = 1; frame_done = 0.
- Prescaler counts every clock; tick when it equals 2^SCAN_DIV_BITS-1.
- idx advances on tick: N-1 wraps to 0, else idx+1.
- frame_done = 1 for exactly the cycle after the tick at idx = N-1.
- Load handshake:
  - load = 1 writes staging and sets pending.
  - A later load before commit overwrites staging; the last load wins.
  - Commit happens on the wrap tick (idx = N-1): shadow <= staging, pending <= 0.
  - load in the same cycle as the commit: shadow takes the old staging, staging takes the new data, pending stays 1.
  - Display uses only the shadow registers, so a frame never mixes old and new data.
- Leading-zero suppression (lz_suppress = 1): scanning from digit N-1 downward, each zero nibble is suppressed until the first nonzero nibble. Digit 0 is never suppressed. Evaluated on shadow data.
- Digit dark when any of: blank_mask[idx]; blink_mask[idx] and blink phase = 1; suppressed; or prescaler < GUARD_CYCLES.
- Dark digit: An all 1, Cathodes 7'b1111111, Dp = 1.
- Lit digit: An[idx] = 0, others 1; Dp = ~dp_in[idx].
- Cathode map: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- All outputs are registered: one clock of latency from the internal state (prescaler, idx, blink, shadow).
- No combinational path from any input to any output.
- At most one anode is low in any cycle.
- Reset asserted mid-frame: outputs go dark immediately. After release, scanning restarts at digit 0 with the prescaler at 0, so the first slot begins with its guard interval.

Test Plan:
- Setup: NUM_DIGITS=3, SCAN_DIV_BITS=3, GUARD_CYCLES=2, BLINK_DIV_BITS=7.
- Scan and guard: load digits=12'h5A0, masks 0 -> after commit, each 8-clock slot shows 2 clocks of An=111, then 6 clocks of An=110/101/011 in turn. Cathodes = 0000001 (0) in digit 0's slot, 0001000 (A) in digit 1's, 0100100 (5) in digit 2's. Wrap from idx 2 to 0; frame_done pulses once every 24 clocks.
- Atomic load: load 12'h123 mid-frame, then 12'h456 two cycles later -> pending = 1 until the wrap tick. The next frame shows only 4,5,6 and never 1,2,3.
- Load at commit: load 12'h777 coincident with the wrap tick -> that frame shows the prior staging, pending stays 1, and 777 appears one frame later.
- Leading zeros: digits=12'h005, lz_suppress=1 -> digits 2 and 1 dark, digit 0 shows 5. digits=12'h000 -> only digit 0 shows 0. digits=12'h050 -> digits 1 and 0 lit.
- Blink and Dp: blink_mask=3'b010, dp_in=3'b001 -> digit 1 dark while blink counter MSB = 1 (64 clocks), lit for the other 64. Dp = 0 only in digit 0's lit cycles.
- Reset: pull reset_n low mid-slot -> An=111, Cathodes=1111111, Dp=1 with no clock edge. Shadow cleared, so the display shows 0s after release. The first lit digit is 0 after GUARD_CYCLES+1 clocks.
